// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with prefix support and valid/ready handshake on both sides.
// Optional prefix-overwrite error pulse is enabled by defining IMM_EXT_ERR_EN.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 11,
    parameter int unsigned PFX_W = 5,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_field,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             pfx_used,
    output logic             pfx_err
);

    localparam int unsigned SRC_W = IN_W + PFX_W;
    localparam logic [OUT_W-1:0] MaskIn  = {OUT_W{1'b1}} >> (OUT_W - IN_W);
    localparam logic [OUT_W-1:0] MaskPfx = {OUT_W{1'b1}} >> (OUT_W - SRC_W);

    typedef enum logic [0:0] {StNoPfx, StHasPfx} state_e;

    state_e             state_q, state_d;
    logic [PFX_W-1:0]   pfx_q, pfx_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               pfx_used_q, pfx_used_d;

    logic               accept;
    logic               has_pfx;
    logic               src_msb;
    logic [SRC_W-1:0]   src_wide;
    logic [OUT_W-1:0]   src_z;
    logic [OUT_W-1:0]   src_s;
    logic [OUT_W-1:0]   result;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign has_pfx  = (state_q == StHasPfx);

    // Source is zero-extended first; sign fill covers every bit above the active source width.
    always_comb begin
        src_wide = has_pfx ? {pfx_q, in_field} : {{PFX_W{1'b0}}, in_field};
        src_msb  = has_pfx ? pfx_q[PFX_W-1] : in_field[IN_W-1];
        src_z    = OUT_W'(src_wide);
        src_s    = src_z | (src_msb ? ~(has_pfx ? MaskPfx : MaskIn) : '0);
        unique case (in_mode)
            2'b01:   result = src_z;
            2'b11:   result = src_s << SHL;
            default: result = src_s;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pfx_d       = pfx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        pfx_used_d  = pfx_used_q;
        if (flush) begin
            state_d     = StNoPfx;
            out_valid_d = 1'b0;
            pfx_used_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (in_mode == 2'b10) begin
                    pfx_d   = in_field[PFX_W-1:0];
                    state_d = StHasPfx;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    pfx_used_d  = has_pfx;
                    state_d     = StNoPfx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StNoPfx;
            pfx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pfx_used_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pfx_q       <= pfx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pfx_used_q  <= pfx_used_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pfx_used  = pfx_used_q;

`ifdef IMM_EXT_ERR_EN
    logic pfx_err_q, pfx_err_d;

    // Pulse when a second prefix overwrites one that was never consumed.
    assign pfx_err_d = !flush && accept && (in_mode == 2'b10) && has_pfx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pfx_err_q <= 1'b0;
        end else begin
            pfx_err_q <= pfx_err_d;
        end
    end

    assign pfx_err = pfx_err_q;
`else
    assign pfx_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed scenarios plus random traffic against
// a cycle-level arithmetic reference model.
module tb_imm_extend_pipe;

    localparam int IN_W  = 11;
    localparam int PFX_W = 5;
    localparam int OUT_W = 16;
    localparam int SHL   = 1;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_field;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              pfx_used;
    logic              pfx_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit              m_valid;
    bit [OUT_W-1:0]  m_data;
    bit              m_used;
    bit              m_has;
    bit [PFX_W-1:0]  m_pfx;
    bit              m_err;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .PFX_W (PFX_W),
        .OUT_W (OUT_W),
        .SHL   (SHL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_field  (in_field),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pfx_used  (pfx_used),
        .pfx_err   (pfx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Extension computed as integer arithmetic on the source value.
    function automatic bit [OUT_W-1:0] ref_ext(input bit has, input bit [PFX_W-1:0] p,
                                               input bit [IN_W-1:0] f, input bit [1:0] m);
        longint w;
        longint val;
        w   = has ? IN_W + PFX_W : IN_W;
        val = has ? longint'(p) * (longint'(1) << IN_W) + longint'(f) : longint'(f);
        if (m != 2'b01 && val >= (longint'(1) << (w - 1))) val = val - (longint'(1) << w);
        if (m == 2'b11) val = val * (longint'(1) << SHL);
        return val[OUT_W-1:0];
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_used = 0; m_has = 0; m_pfx = '0; m_err = 0;
    endtask

    task automatic check_outputs(input string where);
        check_eq({where, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check_eq({where, ".out_data"},  32'(out_data),  32'(m_data));
        check_eq({where, ".pfx_used"},  32'(pfx_used),  32'(m_used));
        check_eq({where, ".pfx_err"},   32'(pfx_err),   32'(m_err));
    endtask

    // One clock: drive, check in_ready, advance model at the edge, compare registers after it.
    task automatic cycle(input bit v, input bit [IN_W-1:0] f, input bit [1:0] m,
                         input bit ordy, input bit fl, input string tag);
        bit exp_rdy;
        bit acc;
        in_valid  = v;
        in_field  = f;
        in_mode   = m;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && (!m_valid || ordy);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        m_err = 0;
        if (fl) begin
            m_valid = 0; m_has = 0; m_used = 0;
        end else begin
            if (m_valid && ordy) m_valid = 0;
            if (acc) begin
                if (m == 2'b10) begin
`ifdef IMM_EXT_ERR_EN
                    m_err = m_has;
`endif
                    m_has = 1;
                    m_pfx = f[PFX_W-1:0];
                end else begin
                    m_data  = ref_ext(m_has, m_pfx, f, m);
                    m_valid = 1;
                    m_used  = m_has;
                    m_has   = 0;
                end
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_field = '0; in_mode = '0; out_ready = 0;
        model_reset();
        #2;
        check_outputs("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic modes
        cycle(1, 11'h7FF, 2'b00, 1, 0, "sext");
        check_eq("sext.value", 32'(out_data), 32'h0000FFFF);
        cycle(1, 11'h7FF, 2'b01, 1, 0, "zext");
        check_eq("zext.value", 32'(out_data), 32'h000007FF);
        cycle(1, 11'h400, 2'b11, 1, 0, "shl");
        check_eq("shl.value", 32'(out_data), 32'h0000F800);

        // Prefix then consumer
        cycle(1, 11'h01A, 2'b10, 1, 0, "pfx");
        cycle(1, 11'h123, 2'b00, 1, 0, "pfx_use");
        check_eq("pfx_use.value", 32'(out_data), 32'h0000D123);
        check_eq("pfx_use.flag", 32'(pfx_used), 32'h1);
        cycle(1, 11'h001, 2'b00, 1, 0, "after_pfx");
        check_eq("after_pfx.value", 32'(out_data), 32'h00000001);

        // Backpressure
        for (int i = 0; i < 3; i++) cycle(1, 11'(16 + i), 2'b00, 0, 0, "bp_hold");
        for (int i = 0; i < 4; i++) cycle(1, 11'(32 + i), 2'b01, 1, 0, "bp_release");

        // Double prefix
        cycle(1, 11'h001, 2'b10, 1, 0, "dpfx1");
        cycle(1, 11'h002, 2'b10, 1, 0, "dpfx2");
        cycle(1, 11'h000, 2'b01, 1, 0, "dpfx_use");
        check_eq("dpfx_use.value", 32'(out_data), 32'h00001000);

        // Flush drops input and pending prefix
        cycle(1, 11'h01F, 2'b10, 1, 0, "fl_pfx");
        cycle(1, 11'h7FF, 2'b00, 1, 1, "flush");
        check_eq("flush.valid", 32'(out_valid), 32'h0);
        cycle(1, 11'h7FF, 2'b00, 1, 0, "post_flush");
        check_eq("post_flush.value", 32'(out_data), 32'h0000FFFF);

        // Async reset with a held result and a pending prefix
        cycle(1, 11'h0AB, 2'b00, 0, 0, "pre_rst_a");
        cycle(1, 11'h005, 2'b10, 0, 0, "pre_rst_b");
        cycle(0, 11'h000, 2'b00, 1, 0, "pre_rst_c");
        cycle(1, 11'h00C, 2'b10, 1, 0, "pre_rst_d");
        in_valid = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1, 11'h7FF, 2'b00, 1, 0, "post_rst");
        check_eq("post_rst.value", 32'(out_data), 32'h0000FFFF);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 11'($urandom), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered immediate-extension stage for the decode path; the parametrised successor to the fixed 11-to-16-bit sign extender. It accepts an immediate field plus a mode each transfer. It sign-extends, zero-extends or sign-extends-and-shifts the field to `OUT_W`, and supports an immediate-prefix instruction whose bits are prepended to the next field. It sits between the instruction decoder and the ALU operand mux, with a valid/ready handshake on both sides.

## Interface
- `IN_W`, 11, immediate field width
- `PFX_W`, 5, prefix field width (low `PFX_W` bits of `in_field` are used on a prefix transfer); requires `IN_W+PFX_W <= OUT_W`
- `OUT_W`, 16, output width
- `SHL`, 1, left-shift amount for shift mode (`SHL < OUT_W`)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous clear of prefix and output register
- `in_valid`  in  1  input transfer offered
- `in_ready`  out  1  stage can accept (combinational)
- `in_field`  in  `IN_W`  immediate field
- `in_mode`  in  2  00 sign, 01 zero, 10 prefix, 11 sign+shift
- `out_valid`  out  1  result held in output register
- `out_ready`  in  1  consumer accepts result
- `out_data`  out  `OUT_W`  extended immediate
- `pfx_used`  out  1  current `out_data` consumed a prefix
- `pfx_err`  out  1  one-cycle error pulse (only with `IMM_EXT_ERR_EN`)

## Operation
- State machine: NOPFX (reset) / HASPFX; `pfx_reg[PFX_W-1:0]` holds the latched prefix.
- Accept = `in_valid && in_ready && !flush`; `in_ready = !flush && (!out_valid || out_ready)`.
- Accepted mode 10: latch `in_field[PFX_W-1:0]` into `pfx_reg` and go to HASPFX; no output is produced, and `out_valid` is unaffected except for draining.
- Accepted mode 10 while in HASPFX: the new prefix overwrites the old one and the state stays HASPFX (error pulse per Configuration).
- Accepted mode 00/01/11 in NOPFX: the source is `in_field` (`IN_W` bits).
- Accepted mode 00/01/11 in HASPFX: the source is `{pfx_reg, in_field}` (`IN_W+PFX_W` bits); the state returns to NOPFX and `pfx_used` is set to 1.
- Mode 00: sign-extend the source MSB to `OUT_W`.
- Mode 01: zero-extend.
- Mode 11: sign-extend, then shift left by `SHL`, truncated to `OUT_W`; vacated LSBs are 0.
- Output register loads on a non-prefix accept. `out_valid` clears when `out_ready && out_valid` and no new non-prefix accept happens in that cycle.
- `flush`: next edge sets `out_valid=0`, state to NOPFX, `pfx_used=0`; any input in that cycle is dropped.
- Reset values: `out_valid=0`, `out_data=0`, `pfx_used=0`, `pfx_err=0`, state NOPFX, `pfx_reg=0`.
- Reset mid-operation: a pending prefix and any held result are discarded immediately.

## Timing
- Latency: 1 cycle from accept edge to `out_valid`/`out_data`.
- Throughput: 1 result per cycle when `out_ready` is held high.
- A prefix costs one accepted cycle with no output.
- `out_data` and `pfx_used` remain stable while `out_valid && !out_ready`.
- Same-cycle drain plus new accept: the register reloads and `out_valid` stays 1 with no bubble.
- `in_ready` depends combinationally on `out_ready` and `flush`; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `IMM_EXT_ERR_EN` defined: `pfx_err` pulses high for exactly one cycle, on the edge after a prefix is accepted while in HASPFX; the overwrite still happens.
- `IMM_EXT_ERR_EN` undefined: the `pfx_err` port is present but tied to 0; there is no error logic.

## Test plan
All scenarios use default parameters.
- Reset with `rst_n=0` asynchronously mid-transfer -> all outputs 0 with no clock edge, state NOPFX.
- Mode 00, field 11'h7FF -> `out_data=16'hFFFF` one cycle later. Mode 01, field 11'h7FF -> 16'h07FF. Mode 11, field 11'h400 -> 16'hF800.
- Prefix 5'h1A followed by mode 00, field 11'h123 -> a single output 16'hD123 with `pfx_used=1`. The next field 11'h001 -> 16'h0001 with `pfx_used=0`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0`, `out_data` stable. Release -> back-to-back results with no bubble and no loss.
- Prefix 5'h01, then prefix 5'h02, then mode 01, field 0 -> `out_data=16'h1000`; `pfx_err` pulses once with the macro defined, stays 0 without it.
- Prefix accepted, then `flush` with concurrent `in_valid` -> input dropped, `out_valid=0`. The next mode 00, field 11'h7FF gives 16'hFFFF (no stale prefix).
